// File: rtl/req_arbiter_pkg.sv
// Shared types and constants for the request arbiter and its FIFO-side neighbours.
package req_arbiter_pkg;

    localparam int NUM_REQ_PORTS = 4;
    localparam int REQ_TYPE_W    = 4;
    localparam int REQ_ID_W      = 8;
    localparam int REQ_DATA_W    = 32;

    typedef struct packed {
        logic                  req;
        logic [REQ_TYPE_W-1:0] req_type;
        logic [REQ_ID_W-1:0]   req_id;
        logic [REQ_DATA_W-1:0] req_data1;
        logic [REQ_DATA_W-1:0] req_data2;
    } req_pkt_type;

    // Plain modulo keeps the rotation correct when the port count is not a power of two.
    function automatic int port_add(input int base, input int offset, input int num_ports);
        return (base + offset) % num_ports;
    endfunction

endpackage

// File: rtl/req_arbiter_if.sv
// Bundle of FIFO-head inputs, pop strobes and the registered valid/ready output stage.
interface req_arbiter_if
    import req_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = NUM_REQ_PORTS,
    parameter int CNT_W     = 8
) ();

    localparam int PORT_W = $clog2(NUM_PORTS);

    req_pkt_type             fifo_head [NUM_PORTS];
    logic [NUM_PORTS-1:0]    fifo_read;
    req_pkt_type             out_pkt;
    logic [PORT_W-1:0]       out_port;
    logic                    out_valid;
    logic                    out_ready;
    logic [CNT_W-1:0]        pkt_cnt [NUM_PORTS];

    // master is the arbiter side, slave is the FIFOs plus the downstream consumer.
    modport master (
        input  fifo_head, out_ready,
        output fifo_read, out_pkt, out_port, out_valid, pkt_cnt
    );

    modport slave (
        output fifo_head, out_ready,
        input  fifo_read, out_pkt, out_port, out_valid, pkt_cnt
    );

endinterface

// File: rtl/req_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, last_grant itself last.
module rr_pick
    import req_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = NUM_REQ_PORTS,
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last_grant,
    output logic                 found,
    output logic [PORT_W-1:0]    pick
);

    logic [PORT_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = PORT_W'(port_add(int'(last_grant), k, NUM_PORTS));
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// Round-robin arbiter draining the input FIFOs into one registered valid/ready output,
// with a wrapping per-port count of forwarded packets.
module req_arbiter
    import req_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = NUM_REQ_PORTS,
    parameter int CNT_W     = 8
) (
    input logic         clk,
    input logic         rst_b,
    req_arbiter_if.master bus
);

    localparam int PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] req_vec;
    logic [PORT_W-1:0]    last_grant;
    logic [PORT_W-1:0]    pick;
    logic                 found;
    logic                 slot_free;
    logic                 grant;

    req_pkt_type          out_pkt_q;
    logic [PORT_W-1:0]    out_port_q;
    logic                 out_valid_q;
    logic [CNT_W-1:0]     pkt_cnt_q [NUM_PORTS];

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_vec[i] = bus.fifo_head[i].req;
        end
    end

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .req        (req_vec),
        .last_grant (last_grant),
        .found      (found),
        .pick       (pick)
    );

    // Gating with rst_b keeps the FIFOs from being popped while the output register is held in reset.
    assign slot_free = !out_valid_q || bus.out_ready;
    assign grant     = rst_b && slot_free && found;

    always_comb begin
        bus.fifo_read = '0;
        if (grant) begin
            bus.fifo_read[pick] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid_q <= 1'b0;
            out_pkt_q   <= '0;
            out_port_q  <= '0;
            last_grant  <= PORT_W'(NUM_PORTS - 1);
        end else if (grant) begin
            out_valid_q <= 1'b1;
            out_pkt_q   <= bus.fifo_head[pick];
            out_port_q  <= pick;
            last_grant  <= pick;
        end else if (slot_free) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else if (grant) begin
            pkt_cnt_q[pick] <= pkt_cnt_q[pick] + CNT_W'(1);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pkt   = out_pkt_q;
    assign bus.out_port  = out_port_q;
    assign bus.pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Self-checking bench for req_arbiter: hand-derived vector table plus a scoreboard of granted packets.
module tb_req_arbiter;
    import req_arbiter_pkg::*;

    localparam int NP = 4;

    typedef struct {
        logic [NP-1:0] mask;
        logic          ready;
        logic [NP-1:0] exp_read;
        int            exp_port;
    } vec_t;

    typedef struct {
        int          port;
        req_pkt_type pkt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b = 1'b1;

    req_arbiter_if #(.NUM_PORTS(NP), .CNT_W(8)) bus ();

    req_arbiter #(.NUM_PORTS(NP), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          seq      = 1;
    exp_t        sb [$];
    vec_t        vecs [18];

    logic        mdl_valid;
    req_pkt_type mdl_pkt;
    int          mdl_port;
    int          mdl_last;
    logic [7:0]  mdl_cnt [NP];

    task automatic compare(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic req_pkt_type mk_head(input int port, input logic v, input int s);
        req_pkt_type p;
        p = '0;
        if (v) begin
            p.req       = 1'b1;
            p.req_type  = REQ_TYPE_W'(port);
            p.req_id    = REQ_ID_W'(s * 4 + port);
            p.req_data1 = $urandom;
            p.req_data2 = 32'(s * 7 + port);
        end
        return p;
    endfunction

    task automatic resetModel();
        mdl_valid = 1'b0;
        mdl_pkt   = '0;
        mdl_port  = 0;
        mdl_last  = NP - 1;
        for (int i = 0; i < NP; i++) mdl_cnt[i] = '0;
        sb.delete();
    endtask

    task automatic checkOutput(input logic grant, input logic slot_free, input int exp_port, input string tag);
        exp_t e;
        if (grant) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL %s scoreboard: got empty queue, expected a packet", tag);
            end else begin
                e = sb.pop_front();
                mdl_valid = 1'b1;
                mdl_pkt   = e.pkt;
                mdl_port  = e.port;
                mdl_last  = e.port;
                mdl_cnt[e.port] = mdl_cnt[e.port] + 8'd1;
            end
        end else if (slot_free) begin
            mdl_valid = 1'b0;
        end
        compare({tag, " out_valid"}, 96'(bus.out_valid), 96'(mdl_valid));
        if (mdl_valid) begin
            compare({tag, " out_pkt"}, 96'(bus.out_pkt), 96'(mdl_pkt));
            compare({tag, " out_port"}, 96'(bus.out_port), 96'(mdl_port));
        end
        for (int i = 0; i < NP; i++) begin
            compare($sformatf("%s pkt_cnt[%0d]", tag, i), 96'(bus.pkt_cnt[i]), 96'(mdl_cnt[i]));
        end
        if (exp_port >= 0) begin
            compare({tag, " table valid"}, 96'(bus.out_valid), 96'(1));
            compare({tag, " table port"}, 96'(bus.out_port), 96'(exp_port));
        end else begin
            compare({tag, " table drained"}, 96'(bus.out_valid), 96'(0));
        end
    endtask

    // Called at (or just after) a falling edge with fifo_head already driven.
    task automatic stepCycle(input logic ready, input logic [NP-1:0] exp_read, input int exp_port, input string tag);
        logic [NP-1:0] mask;
        logic [NP-1:0] mdl_read;
        logic          slot_free;
        logic          found;
        logic          grant;
        int            pick;
        bus.out_ready = ready;
        for (int i = 0; i < NP; i++) mask[i] = bus.fifo_head[i].req;
        #1;
        slot_free = !mdl_valid || ready;
        found = 1'b0;
        pick  = 0;
        for (int k = 1; k <= NP; k++) begin
            int idx;
            idx = (mdl_last + k) % NP;
            if (!found && mask[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        grant    = found && slot_free;
        mdl_read = grant ? NP'(1 << pick) : '0;
        compare({tag, " fifo_read model"}, 96'(bus.fifo_read), 96'(mdl_read));
        compare({tag, " fifo_read table"}, 96'(bus.fifo_read), 96'(exp_read));
        if (grant) sb.push_back('{pick, bus.fifo_head[pick]});
        @(posedge clk);
        #1;
        checkOutput(grant, slot_free, exp_port, tag);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [NP-1:0] mask, input logic ready,
                                 input logic [NP-1:0] exp_read, input int exp_port, input string tag);
        for (int i = 0; i < NP; i++) bus.fifo_head[i] = mk_head(i, mask[i], seq);
        seq++;
        stepCycle(ready, exp_read, exp_port, tag);
    endtask

    // Leaves rst_b released just after a falling edge; the caller drives the next cycle immediately.
    task automatic doReset();
        rst_b = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NP; i++) bus.fifo_head[i] = mk_head(i, 1'b1, seq);
        seq++;
        @(negedge clk);
        @(negedge clk);
        #1;
        compare("reset fifo_read", 96'(bus.fifo_read), 96'(0));
        compare("reset out_valid", 96'(bus.out_valid), 96'(0));
        compare("reset out_pkt", 96'(bus.out_pkt), 96'(0));
        compare("reset out_port", 96'(bus.out_port), 96'(0));
        for (int i = 0; i < NP; i++) begin
            compare($sformatf("reset pkt_cnt[%0d]", i), 96'(bus.pkt_cnt[i]), 96'(0));
        end
        resetModel();
        rst_b = 1'b1;
    endtask

    initial begin
        // Fairness from reset, skip, backpressure, drain, grant into an empty slot under ready=0.
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 2};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 3};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 0};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1};
        vecs[6]  = '{4'b1010, 1'b1, 4'b1000, 3};
        vecs[7]  = '{4'b1010, 1'b1, 4'b0010, 1};
        vecs[8]  = '{4'b1010, 1'b1, 4'b1000, 3};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 3};
        vecs[10] = '{4'b1111, 1'b0, 4'b0000, 3};
        vecs[11] = '{4'b1111, 1'b0, 4'b0000, 3};
        vecs[12] = '{4'b1111, 1'b1, 4'b0001, 0};
        vecs[13] = '{4'b0000, 1'b1, 4'b0000, -1};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, -1};
        vecs[15] = '{4'b0100, 1'b0, 4'b0100, 2};
        vecs[16] = '{4'b0011, 1'b0, 4'b0000, 2};
        vecs[17] = '{4'b0011, 1'b1, 4'b0001, 0};

        bus.out_ready = 1'b0;
        for (int i = 0; i < NP; i++) bus.fifo_head[i] = '0;
        #2;
        doReset();
        for (int v = 0; v < 18; v++) begin
            applyStimulus(vecs[v].mask, vecs[v].ready, vecs[v].exp_read, vecs[v].exp_port,
                          $sformatf("vec%0d", v));
        end

        // Single requester on port 2 straight after reset.
        doReset();
        for (int i = 0; i < NP; i++) bus.fifo_head[i] = '0;
        bus.fifo_head[2].req       = 1'b1;
        bus.fifo_head[2].req_type  = 4'h2;
        bus.fifo_head[2].req_id    = 8'd5;
        bus.fifo_head[2].req_data1 = 32'hdead_beef;
        bus.fifo_head[2].req_data2 = 32'h0000_1234;
        stepCycle(1'b1, 4'b0100, 2, "single");
        compare("single req_id", 96'(bus.out_pkt.req_id), 96'(5));
        compare("single pkt_cnt[2]", 96'(bus.pkt_cnt[2]), 96'(1));

        // 256 grants to port 0 wrap its counter back to zero.
        for (int n = 0; n < 256; n++) begin
            applyStimulus(4'b0001, 1'b1, 4'b0001, 0, "wrap");
        end
        compare("wrap pkt_cnt[0]", 96'(bus.pkt_cnt[0]), 96'(0));

        // Reset between clock edges while a packet is held under backpressure.
        applyStimulus(4'b0001, 1'b0, 4'b0000, 0, "hold");
        #2;
        rst_b = 1'b0;
        #1;
        compare("async reset out_valid", 96'(bus.out_valid), 96'(0));
        compare("async reset out_pkt", 96'(bus.out_pkt), 96'(0));
        compare("async reset fifo_read", 96'(bus.fifo_read), 96'(0));
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
